// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding selects, FSM state
// encoding and the per-stage shadow record of the E/M/W pipeline slots.
package hazard_pkg;

  localparam int HZ_ADDR_W = 4;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef logic [0:0] hz_state_t;
  localparam hz_state_t RUN      = 1'b0;
  localparam hz_state_t PC_DRAIN = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [HZ_ADDR_W-1:0] wa;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 pc_src;
    logic [HZ_ADDR_W-1:0] ra1;
    logic [HZ_ADDR_W-1:0] ra2;
  } stage_info_t;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-operand forwarding compare: picks the youngest in-flight writer of the
// execute-stage source register, never forwarding the PC register.
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter logic [HZ_ADDR_W-1:0] PC_REG = 4'd15
) (
  input  logic [HZ_ADDR_W-1:0] ra,
  input  stage_info_t          m_stage,
  input  stage_info_t          w_stage,
  output fwd_sel_t             sel
);

  always_comb begin
    sel = FWD_RF;
    if (ra != PC_REG) begin
      if (m_stage.valid && m_stage.reg_write && (m_stage.wa == ra)) begin
        sel = FWD_M;
      end else if (w_stage.valid && w_stage.reg_write && (w_stage.wa == ra)) begin
        sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: shadow E/M/W destination tracking, operand
// forwarding selects, load-use stall, PC-write drain FSM and a stall counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W = HZ_ADDR_W,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [ADDR_W-1:0] WriteAddrD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              PCSrcD,
  input  logic              BranchTakenE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCount
);

  localparam logic [ADDR_W-1:0] PC_IDX    = ADDR_W'(PC_REG);
  localparam logic [1:0]        DRAIN_LEN = 2'd3;

  stage_info_t e_reg, m_reg, w_reg;
  stage_info_t d_info, e_next;
  hz_state_t   state_reg, state_next;
  logic [1:0]  drain_cnt_reg, drain_cnt_next;
  logic        flushd_reg;
  logic        active_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic d_valid, load_use, stall_lu, drain, branch, accept;
  logic stall_f, stall_d, flush_d, flush_e;

  logic [ADDR_W-1:0] ra_e [2];
  fwd_sel_t          fwd_sel [2];

  // The decode slot holds a real instruction only once out of reset, outside
  // a PC drain, and when the decode register was not cleared last cycle.
  assign d_valid = active_reg && (state_reg == RUN) && !flushd_reg;

  assign load_use = d_valid && e_reg.valid && e_reg.mem_to_reg &&
                    (((e_reg.wa == RA1D) && (RA1D != PC_IDX)) ||
                     ((e_reg.wa == RA2D) && (RA2D != PC_IDX)));

  assign branch   = active_reg && BranchTakenE;
  assign stall_lu = load_use && !BranchTakenE;
  assign drain    = active_reg && (state_reg == PC_DRAIN);
  assign accept   = d_valid && PCSrcD && !stall_lu && !BranchTakenE;

  assign stall_f = stall_lu || drain;
  assign stall_d = stall_lu;
  assign flush_d = branch || drain;
  assign flush_e = stall_lu || branch;

  always_comb begin
    d_info = '{valid:      d_valid,
               wa:         WriteAddrD,
               reg_write:  RegWriteD,
               mem_to_reg: MemtoRegD,
               pc_src:     PCSrcD,
               ra1:        RA1D,
               ra2:        RA2D};
    e_next = d_info;
    if (flush_e || !d_valid) begin
      e_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_reg      <= '0;
      m_reg      <= '0;
      w_reg      <= '0;
      flushd_reg <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      e_reg      <= e_next;
      m_reg      <= e_reg;
      w_reg      <= m_reg;
      flushd_reg <= flush_d;
      active_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      RUN: begin
        if (accept) begin
          state_next     = PC_DRAIN;
          drain_cnt_next = DRAIN_LEN;
        end
      end
      PC_DRAIN: begin
        if (branch) begin
          state_next = RUN;
        end else if ((drain_cnt_reg == 2'd1) && w_reg.valid && w_reg.pc_src) begin
          state_next = RUN;
        end else if (drain_cnt_reg != 2'd1) begin
          drain_cnt_next = drain_cnt_reg - 2'd1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      drain_cnt_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (stall_f && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign ra_e[0] = e_reg.ra1;
  assign ra_e[1] = e_reg.ra2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    hazard_fwd_cmp #(
      .PC_REG(PC_IDX)
    ) u_cmp (
      .ra     (ra_e[gi]),
      .m_stage(m_reg),
      .w_stage(w_reg),
      .sel    (fwd_sel[gi])
    );
  end

  assign forwardAE  = active_reg ? fwd_sel[0] : FWD_RF;
  assign forwardBE  = active_reg ? fwd_sel[1] : FWD_RF;
  assign StallF     = stall_f;
  assign StallD     = stall_d;
  assign FlushD     = flush_d;
  assign FlushE     = flush_e;
  assign StallCount = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector bench for hazard_unit: forwarding, load-use, PC drain,
// branch priority, mid-drain reset and counter saturation.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, WriteAddrD;
  logic       RegWriteD, MemtoRegD, PCSrcD, BranchTakenE;
  logic [1:0] forwardAE, forwardBE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [15:0] StallCount;

  logic [1:0] fa_s, fb_s;
  logic       sf_s, sd_s, fd_s, fe_s;
  logic [2:0] cnt_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_unit u_dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WriteAddrD(WriteAddrD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .BranchTakenE(BranchTakenE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount)
  );

  // Narrow-counter copy: reaches all-ones within the run to show saturation.
  hazard_unit #(.CNT_W(3)) u_dut_sat (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WriteAddrD(WriteAddrD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .BranchTakenE(BranchTakenE),
    .forwardAE(fa_s), .forwardBE(fb_s),
    .StallF(sf_s), .StallD(sd_s), .FlushD(fd_s), .FlushE(fe_s),
    .StallCount(cnt_s)
  );

  typedef struct {
    logic [3:0] ra1, ra2, wa;
    logic       rw, m2r, pcs, bt;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
    int         cnt;
  } vec_t;

  localparam int NV = 46;
  vec_t vecs [NV];

  function automatic vec_t mk(input int ra1, ra2, wa, rw, m2r, pcs, bt,
                              input int fa, fb, sf, sd, fd, fe, cnt);
    vec_t v;
    v.ra1 = 4'(ra1); v.ra2 = 4'(ra2); v.wa = 4'(wa);
    v.rw = 1'(rw); v.m2r = 1'(m2r); v.pcs = 1'(pcs); v.bt = 1'(bt);
    v.fa = 2'(fa); v.fb = 2'(fb);
    v.sf = 1'(sf); v.sd = 1'(sd); v.fd = 1'(fd); v.fe = 1'(fe);
    v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RA1D = v.ra1; RA2D = v.ra2; WriteAddrD = v.wa;
    RegWriteD = v.rw; MemtoRegD = v.m2r; PCSrcD = v.pcs; BranchTakenE = v.bt;
  endtask

  // Called at posedge+1; drives, samples mid-cycle, returns at next posedge+1.
  task automatic run_vec(input string tag, input vec_t v);
    drive(v);
    #4;
    $display("%s: ra1=%0d ra2=%0d wa=%0d pcs=%0d bt=%0d -> fA=%0d fB=%0d sF=%0d sD=%0d fD=%0d fE=%0d cnt=%0d sat=%0d",
             tag, v.ra1, v.ra2, v.wa, v.pcs, v.bt, forwardAE, forwardBE,
             StallF, StallD, FlushD, FlushE, StallCount, cnt_s);
    chk({tag, ".forwardAE"}, int'(forwardAE), int'(v.fa));
    chk({tag, ".forwardBE"}, int'(forwardBE), int'(v.fb));
    chk({tag, ".StallF"},    int'(StallF),    int'(v.sf));
    chk({tag, ".StallD"},    int'(StallD),    int'(v.sd));
    chk({tag, ".FlushD"},    int'(FlushD),    int'(v.fd));
    chk({tag, ".FlushE"},    int'(FlushE),    int'(v.fe));
    chk({tag, ".StallCount"}, int'(StallCount), v.cnt);
    chk({tag, ".StallCountSat"}, int'(cnt_s), (v.cnt > 7) ? 7 : v.cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".forwardAE"}, int'(forwardAE), 0);
    chk({tag, ".forwardBE"}, int'(forwardBE), 0);
    chk({tag, ".StallF"},    int'(StallF),    0);
    chk({tag, ".StallD"},    int'(StallD),    0);
    chk({tag, ".FlushD"},    int'(FlushD),    0);
    chk({tag, ".FlushE"},    int'(FlushE),    0);
    chk({tag, ".StallCount"}, int'(StallCount), 0);
    chk({tag, ".StallCountSat"}, int'(cnt_s), 0);
  endtask

  initial begin
    vec_t nopv, pcw;
    //               ra1 ra2 wa rw m2r pcs bt   fa fb sf sd fd fe cnt
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(6, 7, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 3, 2, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(6, 7, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 3, 2, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(6, 7, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(6, 7, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 2, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0,   2, 2, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(8, 0, 4, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(4, 4, 5, 1, 0, 0, 0,   0, 0, 1, 1, 0, 1, 0);
    vecs[15] = mk(4, 4, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1);
    vecs[17] = mk(8, 0, 15, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    vecs[18] = mk(15, 6, 9, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    vecs[20] = mk(8, 0, 10, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    vecs[21] = mk(6, 10, 11, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1);
    vecs[22] = mk(6, 10, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 2);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2);
    vecs[25] = mk(8, 0, 4, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 2);
    vecs[26] = mk(4, 4, 5, 1, 0, 0, 1,   0, 0, 0, 0, 1, 1, 2);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2);
    vecs[28] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 2);
    vecs[29] = mk(6, 0, 15, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 2);
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 2);
    vecs[31] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 3);
    vecs[32] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 4);
    vecs[33] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 5);
    vecs[34] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 5);
    vecs[35] = mk(8, 0, 4, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 5);
    vecs[36] = mk(4, 0, 15, 1, 0, 1, 0,  0, 0, 1, 1, 0, 1, 5);
    vecs[37] = mk(4, 0, 15, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 6);
    vecs[38] = mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1, 0, 6);
    vecs[39] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 7);
    vecs[40] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 8);
    vecs[41] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 9);
    vecs[42] = mk(6, 0, 15, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 9);
    vecs[43] = mk(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 1, 1, 9);
    vecs[44] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 10);
    vecs[45] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 10);

    nopv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pcw  = mk(6, 0, 15, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10);

    // Reset held with a branch and a load-use-looking pattern on the inputs.
    reset = 1'b0;
    drive(mk(4, 4, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk_all_zero("reset_held");
    drive(nopv);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Enter a PC drain, then pull reset in the middle of a drain cycle.
    run_vec("rst_pcw", pcw);
    drive(nopv);
    #2;
    chk("rst_drain.StallF", int'(StallF), 1);
    chk("rst_drain.FlushD", int'(FlushD), 1);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_vec("post0", nopv);
    run_vec("post1", mk(6, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec("post2", mk(1, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec("post3", mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    run_vec("post4", nopv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
